mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (CPU/DMA) arbiter in front of a single-port synchronous RAM.
// Each transaction walks IDLE -> ACCESS -> RESP. The CPU has fixed priority.
// A 2-bit streak counter stops the CPU from starving the DMA port, and a
// CPU lock keeps the DMA port out for atomic sequences.
//
// Handshake: a requester holds req/we/addr/wdata stable from req rise until
// it samples ack high. It drops or re-presents req on that same edge. ack is
// a single-cycle pulse in RESP, and only the owner's ack is driven.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  // CPU port
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [9:0]  cpu_addr,
  input  logic [15:0] cpu_wdata,
  input  logic        cpu_lock,
  output logic        cpu_ack,
  output logic [15:0] cpu_rdata,
  // DMA port
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [9:0]  dma_addr,
  input  logic [15:0] dma_wdata,
  output logic        dma_ack,
  output logic [15:0] dma_rdata,
  // RAM port (read data valid the cycle after the address)
  output logic [9:0]  ram_addr,
  output logic [15:0] ram_din,
  output logic        ram_write,
  input  logic [15:0] ram_dout,
  // Status
  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  streak;
  logic        lock_flag;
  logic        lock_active;
  logic        grant_cpu;
  logic        grant_dma;
  logic [15:0] cpu_rdata_q;
  logic [15:0] dma_rdata_q;

  // The lock only binds while the CPU keeps cpu_lock high. Dropping it
  // releases the DMA port in the same IDLE cycle.
  assign lock_active = lock_flag & cpu_lock;

  // Arbitration: grants are only made in IDLE.
  always_comb begin
    grant_cpu = 1'b0;
    grant_dma = 1'b0;
    if (state == ST_IDLE) begin
      if (lock_active) begin
        grant_cpu = cpu_req;
      end else if (cpu_req && dma_req) begin
        if (streak == 2'd3) grant_dma = 1'b1;
        else                grant_cpu = 1'b1;
      end else begin
        grant_cpu = cpu_req;
        grant_dma = dma_req;
      end
    end
  end

  // Next-state logic: ACCESS and RESP always last exactly one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (grant_cpu || grant_dma) state_nxt = ST_ACCESS;
      ST_ACCESS: state_nxt = ST_RESP;
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Capture the winner's command into the RAM port at the grant edge.
  // The write strobe is cleared when ACCESS ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr  <= '0;
      ram_din   <= '0;
      ram_write <= 1'b0;
      owner     <= 1'b0;
    end else if (grant_dma) begin
      ram_addr  <= dma_addr;
      ram_din   <= dma_wdata;
      ram_write <= dma_we;
      owner     <= 1'b1;
    end else if (grant_cpu) begin
      ram_addr  <= cpu_addr;
      ram_din   <= cpu_wdata;
      ram_write <= cpu_we;
      owner     <= 1'b0;
    end else if (state == ST_ACCESS) begin
      ram_write <= 1'b0;
    end
  end

  // Starvation guard and lock flag. Both are updated in IDLE only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak    <= 2'd0;
      lock_flag <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (grant_dma) begin
        streak <= 2'd0;
      end else if (grant_cpu && !lock_active) begin
        if (!dma_req)             streak <= 2'd0;
        else if (streak != 2'd3)  streak <= streak + 2'd1;
      end
      if (grant_cpu && cpu_lock) lock_flag <= 1'b1;
      else if (!cpu_lock)        lock_flag <= 1'b0;
    end
  end

  // Per-port read-data hold registers. They load the RAM output as RESP ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else if (state == ST_RESP) begin
      if (owner) dma_rdata_q <= ram_dout;
      else       cpu_rdata_q <= ram_dout;
    end
  end

  // RAM data only becomes valid inside RESP, so it is passed straight
  // through to the owner during that cycle. Otherwise the hold value is shown.
  assign busy      = (state != ST_IDLE);
  assign cpu_ack   = (state == ST_RESP) && !owner;
  assign dma_ack   = (state == ST_RESP) && owner;
  assign cpu_rdata = cpu_ack ? ram_dout : cpu_rdata_q;
  assign dma_rdata = dma_ack ? ram_dout : dma_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter. It provides a behavioural synchronous RAM, CPU and
// DMA driver tasks, a per-port scoreboard of expected read data, and an
// expected grant-order queue.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req, cpu_we, cpu_lock;
  logic [9:0]  cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;
  logic        dma_req, dma_we;
  logic [9:0]  dma_addr;
  logic [15:0] dma_wdata;
  logic        dma_ack;
  logic [15:0] dma_rdata;
  logic [9:0]  ram_addr;
  logic [15:0] ram_din;
  logic        ram_write;
  logic [15:0] ram_dout;
  logic        busy, owner;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_lock(cpu_lock), .cpu_ack(cpu_ack),
    .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_write(ram_write),
    .ram_dout(ram_dout), .busy(busy), .owner(owner)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural RAM (read returns old data) ------
  logic [15:0] mem [1024];
  always @(posedge clk) begin
    if (ram_write) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [15:0] shadow [1024];
  logic [16:0] cpu_exp_q[$];   // {we, expected read data}
  logic [16:0] dma_exp_q[$];
  logic        ord_q[$];       // expected owner of each ack, 0=CPU 1=DMA
  logic [16:0] cpu_e, dma_e;
  int cpu_ack_cyc = 0;
  int dma_ack_cyc = 0;
  int dma_ack_prev = 0;
  int dma_ack_cnt = 0;
  int wr_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (cpu_ack || dma_ack) check("ack_exclusive", 32'(cpu_ack & dma_ack), 32'd0);
      if (cpu_ack) begin
        cpu_ack_cyc = cyc;
        check("cpu_ack_expected", 32'(cpu_exp_q.size() != 0), 32'd1);
        if (cpu_exp_q.size() != 0) begin
          cpu_e = cpu_exp_q.pop_front();
          if (!cpu_e[16]) check("cpu_rdata", 32'(cpu_rdata), 32'(cpu_e[15:0]));
        end
        if (ord_q.size() != 0) check("grant_order_cpu", 32'd0, 32'(ord_q.pop_front()));
      end
      if (dma_ack) begin
        dma_ack_prev = dma_ack_cyc;
        dma_ack_cyc  = cyc;
        dma_ack_cnt++;
        check("dma_ack_expected", 32'(dma_exp_q.size() != 0), 32'd1);
        if (dma_exp_q.size() != 0) begin
          dma_e = dma_exp_q.pop_front();
          if (!dma_e[16]) check("dma_rdata", 32'(dma_rdata), 32'(dma_e[15:0]));
        end
        if (ord_q.size() != 0) check("grant_order_dma", 32'd1, 32'(ord_q.pop_front()));
      end
      if (ram_write) begin
        wr_cnt++;
        check("ram_write_only_busy", 32'(busy), 32'd1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Each task starts one cycle after a rising edge, holds the request until
  // ack is seen, then drops req just after the edge that samples ack.
  // cpu_lock is left as driven so that callers can keep a lock open.
  task automatic cpu_txn(input logic we, input logic [9:0] addr,
                         input logic [15:0] data, input logic lock);
    int n;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = data; cpu_lock = lock;
    if (we) begin
      shadow[addr] = data;
      cpu_exp_q.push_back({1'b1, data});
    end else begin
      cpu_exp_q.push_back({1'b0, shadow[addr]});
    end
    n = 0;
    @(negedge clk);
    while (!cpu_ack && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("cpu_ack_timeout", 32'(cpu_ack), 32'd1);
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
  endtask

  task automatic dma_txn(input logic we, input logic [9:0] addr, input logic [15:0] data);
    int n;
    dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = data;
    if (we) begin
      shadow[addr] = data;
      dma_exp_q.push_back({1'b1, data});
    end else begin
      dma_exp_q.push_back({1'b0, shadow[addr]});
    end
    n = 0;
    @(negedge clk);
    while (!dma_ack && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("dma_ack_timeout", 32'(dma_ack), 32'd1);
    @(posedge clk);
    #1;
    dma_req = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  int t0, wr0, dack0;
  logic busy_seen;
  logic [15:0] rdata_rst;

  initial begin
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; cpu_lock = 0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;

    // Reset values while rst_n is low.
    #2;
    check("rst_ram_write", 32'(ram_write), 32'd0);
    check("rst_ram_addr",  32'(ram_addr),  32'd0);
    check("rst_ram_din",   32'(ram_din),   32'd0);
    check("rst_acks",      32'({cpu_ack, dma_ack}), 32'd0);
    check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    check("rst_dma_rdata", 32'(dma_rdata), 32'd0);
    check("rst_owner_busy", 32'({owner, busy}), 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    // CPU write 0xBEEF @5 and read it back: 6 cycles, 1 write cycle.
    t0 = cyc; wr0 = wr_cnt;
    ord_q.push_back(1'b0); ord_q.push_back(1'b0);
    cpu_txn(1'b1, 10'h005, 16'hBEEF, 1'b0);
    check("first_ack_latency", 32'(cpu_ack_cyc - t0), 32'd2);
    check("write_cycles", 32'(wr_cnt - wr0), 32'd1);
    cpu_txn(1'b0, 10'h005, 16'h0000, 1'b0);
    check("wr_rd_total_latency", 32'(cpu_ack_cyc - t0), 32'd5);
    check("read_no_write", 32'(wr_cnt - wr0), 32'd1);

    // Isolation: DMA reads 0x1234 @3FF; CPU sees no ack and keeps BEEF.
    ord_q.push_back(1'b0); ord_q.push_back(1'b0); ord_q.push_back(1'b1);
    cpu_txn(1'b1, 10'h3FF, 16'h1234, 1'b0);
    cpu_txn(1'b0, 10'h005, 16'h0000, 1'b0);
    dack0 = dma_ack_cnt;
    dma_txn(1'b0, 10'h3FF, 16'h0000);
    check("iso_dma_rdata_hold", 32'(dma_rdata), 32'h1234);
    check("iso_cpu_rdata_hold", 32'(cpu_rdata), 32'hBEEF);
    check("iso_dma_ack_count", 32'(dma_ack_cnt - dack0), 32'd1);

    // Preload addresses for the contention and lock phases.
    for (int i = 0; i < 6; i++) begin
      ord_q.push_back(1'b0);
      cpu_txn(1'b1, 10'h020 + 10'(i), 16'($urandom_range(0, 16'hFFFF)), 1'b0);
    end
    for (int j = 0; j < 2; j++) begin
      ord_q.push_back(1'b1);
      dma_txn(1'b1, 10'h040 + 10'(j), 16'($urandom_range(0, 16'hFFFF)));
    end

    // Contention: both ports held. Expect CPU,CPU,CPU,DMA repeating.
    for (int k = 0; k < 8; k++) ord_q.push_back((k % 4) == 3);
    fork
      for (int i = 0; i < 6; i++) cpu_txn(1'b0, 10'h020 + 10'(i), 16'h0, 1'b0);
      for (int j = 0; j < 2; j++) dma_txn(1'b0, 10'h040 + 10'(j), 16'h0);
    join
    check("dma_ack_period", 32'(dma_ack_cyc - dma_ack_prev), 32'd12);
    check("contention_order_done", 32'(ord_q.size()), 32'd0);

    // Lock at streak 3: the 4th CPU grant wins under lock and the streak
    // must stay at 3. The DMA then wins as soon as the lock is dropped.
    ord_q.push_back(1'b0); ord_q.push_back(1'b0); ord_q.push_back(1'b0);
    ord_q.push_back(1'b0); ord_q.push_back(1'b1); ord_q.push_back(1'b0);
    fork
      begin
        cpu_txn(1'b0, 10'h020, 16'h0, 1'b0);
        cpu_txn(1'b0, 10'h021, 16'h0, 1'b0);
        cpu_txn(1'b0, 10'h022, 16'h0, 1'b1);
        cpu_txn(1'b0, 10'h023, 16'h0, 1'b1);
        cpu_txn(1'b0, 10'h024, 16'h0, 1'b0);
      end
      dma_txn(1'b0, 10'h040, 16'h0);
    join
    check("lock_order_done", 32'(ord_q.size()), 32'd0);

    // Lock held with cpu_req low: no grant at all until cpu_lock drops.
    ord_q.push_back(1'b0); ord_q.push_back(1'b1);
    cpu_txn(1'b0, 10'h025, 16'h0, 1'b1);
    dack0 = dma_ack_cnt;
    fork
      dma_txn(1'b0, 10'h041, 16'h0);
      begin
        busy_seen = 1'b0;
        repeat (6) begin
          @(negedge clk);
          busy_seen = busy_seen | busy;
        end
        check("lock_idle_no_grant", 32'(busy_seen), 32'd0);
        check("lock_idle_no_dma_ack", 32'(dma_ack_cnt - dack0), 32'd0);
        @(posedge clk); #1;
        cpu_lock = 1'b0;
      end
    join
    check("lock_release_dma_ack", 32'(dma_ack_cnt - dack0), 32'd1);

    // Reset during a DMA write ACCESS. The write is cancelled at once and
    // the held request is re-granted at the first edge after release.
    dack0 = dma_ack_cnt;
    fork
      dma_txn(1'b1, 10'h050, 16'hA5C3);
      begin
        @(posedge clk);      // grant edge, now in ACCESS
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ram_write", 32'(ram_write), 32'd0);
        check("mid_rst_busy_owner", 32'({busy, owner}), 32'd0);
        check("mid_rst_ram_addr_din", 32'({ram_addr, ram_din}), 32'd0);
        check("mid_rst_acks", 32'({cpu_ack, dma_ack}), 32'd0);
        check("mid_rst_rdata", 32'({cpu_rdata, dma_rdata}), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", 32'(busy), 32'd0);
        @(negedge clk);
        check("post_rst_regrant", 32'({busy, owner, ram_write}), 32'h7);
        check("post_rst_addr", 32'(ram_addr), 32'h050);
      end
    join
    check("mid_rst_single_ack", 32'(dma_ack_cnt - dack0), 32'd1);

    // The re-granted write must have landed exactly once.
    ord_q.push_back(1'b1);
    dma_txn(1'b0, 10'h050, 16'h0);
    rdata_rst = 16'hA5C3;
    check("post_rst_readback", 32'(dma_rdata), 32'(rdata_rst));

    // Drain.
    repeat (3) @(posedge clk);
    check("cpu_q_empty", 32'(cpu_exp_q.size()), 32'd0);
    check("dma_q_empty", 32'(dma_exp_q.size()), 32'd0);
    check("ord_q_empty", 32'(ord_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
